// File: rtl/dbuffer_access_ctrl_if.sv
// Bundle of the pipeline-side and data-buffer-side signals of the MEM-stage
// data-buffer access controller. The controller uses the slave modport.
interface dbuffer_access_ctrl_if;
   logic [31:0] address;
   logic [2:0]  func3;
   logic        load;
   logic        store;
   logic        addr_ok;
   logic [31:0] store_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        load_valid;
   logic [31:0] load_data;
   logic        bus_err;

   modport master (
      output address, func3, load, store, addr_ok, store_data, mem_rdata, mem_ack,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_valid, load_data, bus_err
   );

   modport slave (
      input  address, func3, load, store, addr_ok, store_data, mem_rdata, mem_ack,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, load_valid, load_data, bus_err
   );
endinterface

// File: rtl/dbuffer_access_ctrl.sv
// MEM-stage data-buffer access controller: one req/ack transaction per load/store.
// Optional ack watchdog enabled by defining DBUF_TIMEOUT_EN.
module dbuffer_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   dbuffer_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  a_lo_q, a_lo_d;

   logic        start;
   logic        timeout;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] shifted;
   logic [31:0] ext;

   // rst in start keeps stall low while reset is held, even with a load pending.
   assign start = ~rst & (state_q == IDLE) & (bus.load | bus.store) & bus.addr_ok;

   always_comb begin
      case (bus.func3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << bus.address[1:0];
            wdata_calc = {4{bus.store_data[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << {bus.address[1], 1'b0};
            wdata_calc = {2{bus.store_data[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = bus.store_data;
         end
      endcase
   end

   always_comb begin
      shifted = bus.mem_rdata >> {a_lo_q, 3'b000};
      case (f3_q)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'b0, shifted[7:0]};
         3'b101:  ext = {16'b0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      is_load_d    = is_load_q;
      f3_d         = f3_q;
      a_lo_d       = a_lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = REQ;
               mem_req_d   = 1'b1;
               // load and store together behaves as a store
               mem_we_d    = bus.store;
               mem_addr_d  = {bus.address[31:2], 2'b00};
               mem_be_d    = be_calc;
               mem_wdata_d = wdata_calc;
               is_load_d   = ~bus.store;
               f3_d        = bus.func3;
               a_lo_d      = bus.address[1:0];
            end
         end
         REQ: begin
            if (bus.mem_ack || timeout) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
               if (bus.mem_ack && is_load_q) begin
                  load_data_d  = ext;
                  load_valid_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_be_q     <= 4'h0;
         mem_wdata_q  <= 32'h0;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         is_load_q    <= 1'b0;
         f3_q         <= 3'b000;
         a_lo_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         is_load_q    <= is_load_d;
         f3_q         <= f3_d;
         a_lo_q       <= a_lo_d;
      end
   end

`ifdef DBUF_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          bus_err_q, bus_err_d;

   // cnt_q counts completed REQ cycles; the last allowed one triggers the abort.
   assign timeout = (state_q == REQ) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (state_q == REQ) begin
         cnt_d = cnt_q + CW'(1);
      end
      bus_err_d = (state_q == REQ) && !bus.mem_ack && timeout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.bus_err = bus_err_q;
`else
   assign timeout     = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.load_data  = load_data_q;
   assign bus.load_valid = load_valid_q;
   assign bus.stall      = start | (state_q == REQ);
endmodule

// File: tb/tb_dbuffer_access_ctrl.sv
// Directed bench for dbuffer_access_ctrl; build with DBUF_TIMEOUT_EN to
// exercise the watchdog (TIMEOUT_CYCLES=4), otherwise the indefinite wait.
module tb_dbuffer_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   dbuffer_access_ctrl_if bif ();

   dbuffer_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   // observations from the most recent run_access
   int          obs_stall, obs_lv, obs_req, obs_berr, obs_hold_bad;
   logic [3:0]  obs_be;
   logic        obs_we;
   logic [31:0] obs_addr, obs_wdata, obs_ld;

   task automatic idle_inputs();
      bif.address = 32'h0; bif.func3 = 3'b000; bif.load = 1'b0; bif.store = 1'b0;
      bif.addr_ok = 1'b0; bif.store_data = 32'h0; bif.mem_rdata = 32'h0; bif.mem_ack = 1'b0;
   endtask

   // Drives one access starting at the current negedge; acks after 'waits' REQ
   // cycles (never if waits >= ncyc). Returns at a negedge.
   task automatic run_access(input logic ld, input logic st, input logic ok,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int waits,
                             input logic [31:0] rd, input int ncyc);
      bif.load = ld; bif.store = st; bif.addr_ok = ok; bif.func3 = f3;
      bif.address = a; bif.store_data = sd; bif.mem_ack = 1'b0; bif.mem_rdata = 32'h0;
      obs_stall = 0; obs_lv = 0; obs_req = 0; obs_berr = 0; obs_hold_bad = 0;
      obs_be = 4'h0; obs_we = 1'b0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_ld = 32'h0;
      for (int c = 0; c < ncyc; c++) begin
         #1;
         if (bif.stall) obs_stall++;
         if (bif.bus_err) obs_berr++;
         if (bif.load_valid) begin
            obs_lv++;
            obs_ld = bif.load_data;
         end
         if (bif.mem_req) begin
            if (obs_req == 0) begin
               obs_be = bif.mem_be; obs_we = bif.mem_we;
               obs_addr = bif.mem_addr; obs_wdata = bif.mem_wdata;
            end else if (bif.mem_be !== obs_be || bif.mem_we !== obs_we ||
                         bif.mem_addr !== obs_addr || bif.mem_wdata !== obs_wdata) begin
               obs_hold_bad++;
            end
            if (obs_req == waits) begin
               bif.mem_ack = 1'b1; bif.mem_rdata = rd;
            end else begin
               bif.mem_ack = 1'b0; bif.mem_rdata = 32'h0;
            end
            obs_req++;
         end else begin
            bif.mem_ack = 1'b0; bif.mem_rdata = 32'h0;
            if (obs_req > 0) begin
               bif.load = 1'b0; bif.store = 1'b0;
            end
         end
         @(negedge clk);
      end
      bif.load = 1'b0; bif.store = 1'b0; bif.addr_ok = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bif.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", bif.mem_req); end
      checks++; if (bif.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bif.mem_we); end
      checks++; if (bif.mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be: got %h want 0", bif.mem_be); end
      checks++; if (bif.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", bif.mem_addr); end
      checks++; if (bif.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", bif.mem_wdata); end
      checks++; if (bif.load_data !== 32'h0) begin failures++; $display("FAIL reset_load_data: got %h want 0", bif.load_data); end
      checks++; if ({bif.load_valid, bif.bus_err, bif.stall} !== 3'b000) begin failures++; $display("FAIL reset_flags: lv/berr/stall got %b want 000", {bif.load_valid, bif.bus_err, bif.stall}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4);
      $display("lw a=100: be=%b we=%b stall=%0d lv=%0d data=%h", obs_be, obs_we, obs_stall, obs_lv, obs_ld);
      checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b0 || obs_addr !== 32'h100) begin failures++; $display("FAIL lw_req: be=%b we=%b addr=%h want 1111/0/00000100", obs_be, obs_we, obs_addr); end
      checks++; if (obs_stall !== 2) begin failures++; $display("FAIL lw_stall: got %0d want 2", obs_stall); end
      checks++; if (obs_lv !== 1 || obs_ld !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: lv=%0d data=%h want 1/deadbeef", obs_lv, obs_ld); end
      checks++; if (bif.load_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_hold: got %h want deadbeef", bif.load_data); end
   endtask

   task automatic test_lb();
      run_access(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF, 4);
      $display("lb a=103: be=%b lv=%0d data=%h", obs_be, obs_lv, obs_ld);
      checks++; if (obs_be !== 4'b1000 || obs_addr !== 32'h100) begin failures++; $display("FAIL lb_be: be=%b addr=%h want 1000/00000100", obs_be, obs_addr); end
      checks++; if (obs_lv !== 1 || obs_ld !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data: lv=%0d data=%h want 1/ffffff80", obs_lv, obs_ld); end
      run_access(1'b1, 1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFFFF, 4);
      $display("lbu a=103: be=%b lv=%0d data=%h", obs_be, obs_lv, obs_ld);
      checks++; if (obs_lv !== 1 || obs_ld !== 32'h00000080) begin failures++; $display("FAIL lbu_data: lv=%0d data=%h want 1/00000080", obs_lv, obs_ld); end
   endtask

   task automatic test_sh();
      run_access(1'b0, 1'b1, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 3, 32'h0, 7);
      $display("sh a=102: be=%b we=%b wdata=%h stall=%0d lv=%0d", obs_be, obs_we, obs_wdata, obs_stall, obs_lv);
      checks++; if (obs_be !== 4'b1100 || obs_we !== 1'b1 || obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_req: be=%b we=%b wdata=%h want 1100/1/abcdabcd", obs_be, obs_we, obs_wdata); end
      checks++; if (obs_stall !== 5 || obs_req !== 4) begin failures++; $display("FAIL sh_stall: stall=%0d req=%0d want 5/4", obs_stall, obs_req); end
      checks++; if (obs_hold_bad !== 0) begin failures++; $display("FAIL sh_hold: %0d changes during REQ want 0", obs_hold_bad); end
      checks++; if (obs_lv !== 0 || bif.load_data !== 32'h00000080) begin failures++; $display("FAIL sh_no_load: lv=%0d load_data=%h want 0/00000080", obs_lv, bif.load_data); end
   endtask

   task automatic test_sb();
      run_access(1'b0, 1'b1, 1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0, 5);
      $display("sb a=201: be=%b addr=%h wdata=%h", obs_be, obs_addr, obs_wdata);
      checks++; if (obs_be !== 4'b0010 || obs_addr !== 32'h200 || obs_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_req: be=%b addr=%h wdata=%h want 0010/00000200/a5a5a5a5", obs_be, obs_addr, obs_wdata); end
   endtask

   task automatic test_fault();
      run_access(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h12345678, 4);
      $display("faulted lw: req=%0d stall=%0d lv=%0d", obs_req, obs_stall, obs_lv);
      checks++; if (obs_req !== 0 || obs_stall !== 0 || obs_lv !== 0) begin failures++; $display("FAIL fault: req=%0d stall=%0d lv=%0d want 0/0/0", obs_req, obs_stall, obs_lv); end
   endtask

   task automatic test_ack_idle();
      bif.mem_ack = 1'b1; bif.mem_rdata = 32'h55555555;
      @(negedge clk);
      bif.mem_ack = 1'b0;
      #1;
      $display("stray ack: req=%b lv=%b data=%h", bif.mem_req, bif.load_valid, bif.load_data);
      checks++; if (bif.mem_req !== 1'b0 || bif.load_valid !== 1'b0 || bif.load_data !== 32'h00000080) begin failures++; $display("FAIL ack_idle: req=%b lv=%b data=%h want 0/0/00000080", bif.mem_req, bif.load_valid, bif.load_data); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_access(1'b1, 1'b0, 1'b1, 3'b001, 32'h100, 32'h0, 0, 32'h1234F00D, 3);
      $display("lh a=100: be=%b data=%h", obs_be, obs_ld);
      checks++; if (obs_be !== 4'b0011 || obs_lv !== 1 || obs_ld !== 32'hFFFFF00D) begin failures++; $display("FAIL b2b_lh: be=%b lv=%0d data=%h want 0011/1/fffff00d", obs_be, obs_lv, obs_ld); end
      run_access(1'b1, 1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 0, 32'h8001FFFF, 3);
      $display("lhu a=102: be=%b stall=%0d data=%h", obs_be, obs_stall, obs_ld);
      checks++; if (obs_be !== 4'b1100 || obs_stall !== 2 || obs_ld !== 32'h00008001) begin failures++; $display("FAIL b2b_lhu: be=%b stall=%0d data=%h want 1100/2/00008001", obs_be, obs_stall, obs_ld); end
      @(negedge clk);
   endtask

   task automatic test_unsupported_func3();
      run_access(1'b1, 1'b0, 1'b1, 3'b011, 32'h104, 32'h0, 0, 32'h89ABCDEF, 4);
      $display("func3=011 a=104: be=%b data=%h", obs_be, obs_ld);
      checks++; if (obs_be !== 4'b1111 || obs_lv !== 1 || obs_ld !== 32'h89ABCDEF) begin failures++; $display("FAIL func3_011: be=%b lv=%0d data=%h want 1111/1/89abcdef", obs_be, obs_lv, obs_ld); end
   endtask

   task automatic test_load_and_store();
      run_access(1'b1, 1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h11111111, 4);
      $display("load+store a=300: we=%b wdata=%h lv=%0d", obs_we, obs_wdata, obs_lv);
      checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'hCAFEF00D || obs_lv !== 0) begin failures++; $display("FAIL ld_st_both: we=%b wdata=%h lv=%0d want 1/cafef00d/0", obs_we, obs_wdata, obs_lv); end
      checks++; if (bif.load_data !== 32'h89ABCDEF) begin failures++; $display("FAIL ld_st_hold: got %h want 89abcdef", bif.load_data); end
   endtask

`ifdef DBUF_TIMEOUT_EN
   task automatic test_timeout();
      run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 1000, 32'h0, 10);
      $display("timeout lw: req=%0d berr=%0d stall=%0d lv=%0d", obs_req, obs_berr, obs_stall, obs_lv);
      checks++; if (obs_req !== 4 || obs_berr !== 1) begin failures++; $display("FAIL timeout: req=%0d berr=%0d want 4/1", obs_req, obs_berr); end
      checks++; if (obs_stall !== 5 || obs_lv !== 0 || bif.load_data !== 32'h89ABCDEF) begin failures++; $display("FAIL timeout_side: stall=%0d lv=%0d data=%h want 5/0/89abcdef", obs_stall, obs_lv, bif.load_data); end
   endtask
`else
   task automatic test_long_wait();
      run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 20, 32'h0BADF00D, 26);
      $display("long wait lw: req=%0d berr=%0d stall=%0d data=%h", obs_req, obs_berr, obs_stall, obs_ld);
      checks++; if (obs_req !== 21 || obs_berr !== 0 || obs_stall !== 22) begin failures++; $display("FAIL long_wait: req=%0d berr=%0d stall=%0d want 21/0/22", obs_req, obs_berr, obs_stall); end
      checks++; if (obs_lv !== 1 || obs_ld !== 32'h0BADF00D) begin failures++; $display("FAIL long_wait_data: lv=%0d data=%h want 1/0badf00d", obs_lv, obs_ld); end
   endtask
`endif

   task automatic test_rst_mid();
      int bad;
      bif.load = 1'b1; bif.addr_ok = 1'b1; bif.func3 = 3'b010; bif.address = 32'h500;
      @(negedge clk);
      #1;
      checks++; if (bif.mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req: got %b want 1", bif.mem_req); end
      bif.mem_ack = 1'b1; bif.mem_rdata = 32'h77777777;
      #1 rst = 1'b1;
      #1;
      $display("rst mid REQ: req=%b be=%h addr=%h stall=%b data=%h", bif.mem_req, bif.mem_be, bif.mem_addr, bif.stall, bif.load_data);
      checks++; if ({bif.mem_req, bif.mem_we, bif.stall, bif.load_valid} !== 4'b0000 || bif.mem_be !== 4'h0 || bif.mem_addr !== 32'h0 || bif.load_data !== 32'h0) begin failures++; $display("FAIL rst_mid_zero: req=%b be=%h addr=%h stall=%b data=%h want all 0", bif.mem_req, bif.mem_be, bif.mem_addr, bif.stall, bif.load_data); end
      @(negedge clk);
      rst = 1'b0; bif.load = 1'b0; bif.addr_ok = 1'b0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bif.mem_req || bif.load_valid || bif.stall) bad++;
         @(negedge clk);
      end
      bif.mem_ack = 1'b0;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_idle: %0d active cycles after reset want 0", bad); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_lw();
      test_lb();
      test_sh();
      test_sb();
      test_fault();
      test_ack_idle();
      test_back_to_back();
      test_unsupported_func3();
      test_load_and_store();
`ifdef DBUF_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
